// File: rtl/clken_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
// Optional runtime divisor writes are enabled by defining CLKEN_RUNTIME_DIV_EN.
package clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/clken_sequencer_if.sv
// Output enables/resets plus the divisor-write handshake of the sequencer.
// The div_wr_* signals exist only when CLKEN_RUNTIME_DIV_EN is defined.
interface clken_sequencer_if #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 8
);

  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] rst_out;
  logic              ready;
`ifdef CLKEN_RUNTIME_DIV_EN
  logic              div_wr_valid;
  logic [3:0]        div_wr_ch;
  logic [DIV_W-1:0]  div_wr_val;
  logic              div_wr_ready;
`endif

  modport master (
    output ce, rst_out, ready
`ifdef CLKEN_RUNTIME_DIV_EN
    , input div_wr_valid, div_wr_ch, div_wr_val,
    output div_wr_ready
`endif
  );

  modport slave (
    input ce, rst_out, ready
`ifdef CLKEN_RUNTIME_DIV_EN
    , output div_wr_valid, div_wr_ch, div_wr_val,
    input div_wr_ready
`endif
  );

endinterface

// File: rtl/clken_div.sv
// One channel divider: counts 0..div-1 while running, registered ce on count 0.
// With CLKEN_RUNTIME_DIV_EN a shadow divisor is loaded on the wrap cycle.
module clken_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             run_next,
  input  logic [DIV_W-1:0] div_init,
`ifdef CLKEN_RUNTIME_DIV_EN
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_val,
  output logic             pending,
`endif
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic [DIV_W-1:0] div_cur, div_nxt;
  logic             wrap;

`ifdef CLKEN_RUNTIME_DIV_EN
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             shadow_vld_q, shadow_vld_d;
  logic             load;

  // Loading only at the wrap (or when the counter is pinned at 0) keeps pulse spacing clean.
  always_comb begin
    div_d        = div_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    load = run && shadow_vld_q &&
           ((div_q <= DIV_W'(1)) || (cnt_q == div_q - DIV_W'(1)));
    if (load) begin
      div_d        = shadow_q;
      shadow_vld_d = 1'b0;
    end
    if (wr_en) begin
      shadow_d     = wr_val;
      shadow_vld_d = 1'b1;
    end
    if (!run_next) shadow_vld_d = 1'b0;
  end

  assign div_cur = div_q;
  assign div_nxt = div_d;
  assign pending = shadow_vld_q;
`else
  assign div_cur = div_init;
  assign div_nxt = div_init;
`endif

  always_comb begin
    wrap = (cnt_q == div_cur - DIV_W'(1));
    cnt_d = '0;
    if (run && run_next && (div_cur != '0) && !wrap) cnt_d = cnt_q + DIV_W'(1);
    ce_d = run_next && (div_nxt != '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
`ifdef CLKEN_RUNTIME_DIV_EN
      div_q        <= div_init;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
`ifdef CLKEN_RUNTIME_DIV_EN
      div_q        <= div_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
`endif
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clken_sequencer.sv
// Post-PLL sequencer: lock filter, staggered reset release and phase-aligned enables.
// Define CLKEN_RUNTIME_DIV_EN to allow divisor writes while running.
module clken_sequencer
  import clken_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {8'd4, 8'd1, 8'd1},
  parameter int                      LOCK_FILTER = 1024,
  parameter int                      STAGGER     = 16
) (
  input logic refclk,
  input logic rst,
  input logic pll_locked,
  clken_sequencer_if.master bus
);

  localparam int LOCK_W   = clog2(LOCK_FILTER);
  localparam int LAST_REL = (NUM_CH - 1) * STAGGER;
  localparam int REL_W    = clog2(LAST_REL + 1);

  logic              lk_meta_q, lk_meta_d;
  logic              lk_s_q, lk_s_d;
  state_t            state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              run_q, run_d;
  logic [NUM_CH-1:0] ce_w;

  // Losing lock anywhere after WAIT_LOCK drops straight back and re-asserts every reset.
  always_comb begin
    lk_meta_d  = pll_locked;
    lk_s_d     = lk_meta_q;
    state_d    = state_q;
    lock_cnt_d = '0;
    rel_cnt_d  = '0;
    rst_out_d  = rst_out_q;
    case (state_q)
      WAIT_LOCK: begin
        rst_out_d = '1;
        if (lk_s_q) begin
          if (lock_cnt_q == LOCK_W'(LOCK_FILTER - 1)) begin
            state_d      = RELEASE;
            rst_out_d[0] = 1'b0;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
      end
      RELEASE: begin
        if (!lk_s_q) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
        end else if (rel_cnt_q == REL_W'(LAST_REL)) begin
          state_d = RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_W'(1);
          for (int i = 1; i < NUM_CH; i++)
            if (rel_cnt_d == REL_W'(i * STAGGER)) rst_out_d[i] = 1'b0;
        end
      end
      RUN: begin
        if (!lk_s_q) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
        end
      end
      default: begin
        state_d   = WAIT_LOCK;
        rst_out_d = '1;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_meta_q  <= 1'b0;
      lk_s_q     <= 1'b0;
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      rel_cnt_q  <= '0;
      rst_out_q  <= '1;
    end else begin
      lk_meta_q  <= lk_meta_d;
      lk_s_q     <= lk_s_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      rst_out_q  <= rst_out_d;
    end
  end

  assign run_q = (state_q == RUN);
  assign run_d = (state_d == RUN);

`ifdef CLKEN_RUNTIME_DIV_EN
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_en;
  logic              accept;

  // Out-of-range channel numbers are accepted but match no divider.
  assign bus.div_wr_ready = run_q && !(|pending);
  assign accept           = bus.div_wr_valid && bus.div_wr_ready;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) wr_en[i] = accept && (bus.div_wr_ch == 4'(i));
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    clken_div #(.DIV_W(DIV_W)) u_div (
      .clk      (refclk),
      .rst      (rst),
      .run      (run_q),
      .run_next (run_d),
      .div_init (DIV_INIT[g*DIV_W +: DIV_W]),
`ifdef CLKEN_RUNTIME_DIV_EN
      .wr_en    (wr_en[g]),
      .wr_val   (bus.div_wr_val),
      .pending  (pending[g]),
`endif
      .ce       (ce_w[g])
    );
  end

  assign bus.ce      = ce_w;
  assign bus.rst_out = rst_out_q;
  assign bus.ready   = run_q;

endmodule

// File: tb/tb_clken_sequencer.sv
// Directed bench for clken_sequencer; a second small instance covers a div=0 channel.
// The runtime-divisor scenario is built only when CLKEN_RUNTIME_DIV_EN is defined.
module tb_clken_sequencer;

  logic refclk = 1'b0;
  logic rst;
  logic pll_locked;
  int   vectors = 0;
  int   miscompares = 0;

  clken_sequencer_if #(.NUM_CH(3), .DIV_W(8)) bus ();
  clken_sequencer_if #(.NUM_CH(2), .DIV_W(8)) bus0 ();

  clken_sequencer #(
    .NUM_CH(3), .DIV_W(8), .DIV_INIT({8'd4, 8'd1, 8'd1}),
    .LOCK_FILTER(8), .STAGGER(4)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .bus(bus.master)
  );

  clken_sequencer #(
    .NUM_CH(2), .DIV_W(8), .DIV_INIT({8'd0, 8'd3}),
    .LOCK_FILTER(1), .STAGGER(1)
  ) dut0 (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .bus(bus0.master)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
`ifdef CLKEN_RUNTIME_DIV_EN
    bus.div_wr_valid = 1'b0; bus.div_wr_ch = '0; bus.div_wr_val = '0;
    bus0.div_wr_valid = 1'b0; bus0.div_wr_ch = '0; bus0.div_wr_val = '0;
`endif
    tick(3);
    vectors++; if (bus.ce !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_ce got %b want 000", bus.ce); end
    vectors++; if (bus.rst_out !== 3'b111) begin miscompares++; $display("[TB] FAIL reset_rst_out got %b want 111", bus.rst_out); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 0", bus.ready); end
    vectors++; if (bus0.rst_out !== 2'b11) begin miscompares++; $display("[TB] FAIL reset_rst_out0 got %b want 11", bus0.rst_out); end
`ifdef CLKEN_RUNTIME_DIV_EN
    vectors++; if (bus.div_wr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_ready got %b want 0", bus.div_wr_ready); end
`endif
    rst = 1'b0;
    tick(3);
    vectors++; if (bus.rst_out !== 3'b111) begin miscompares++; $display("[TB] FAIL idle_rst_out got %b want 111", bus.rst_out); end
    vectors++; if (bus0.ce !== 2'b00) begin miscompares++; $display("[TB] FAIL idle_ce0 got %b want 00", bus0.ce); end
  endtask

  // k counts edges after pll_locked rises: lk_s at 2, release at 10/14/18, RUN at 19.
  task automatic test_lock_stagger();
    logic [2:0] exp_rst, exp_ce;
    logic [1:0] exp_rst0, exp_ce0;
    logic       exp_rdy, exp_rdy0;
    pll_locked = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      exp_rst  = {k < 18, k < 14, k < 10};
      exp_rdy  = (k >= 19);
      exp_ce   = (k >= 19) ? {((k - 19) % 4 == 0), 2'b11} : 3'b000;
      exp_rst0 = {k < 4, k < 3};
      exp_rdy0 = (k >= 5);
      exp_ce0  = {1'b0, (k >= 5) && ((k - 5) % 3 == 0)};
      vectors++; if (bus.rst_out !== exp_rst) begin miscompares++; $display("[TB] FAIL stagger_rst_out k=%0d got %b want %b", k, bus.rst_out, exp_rst); end
      vectors++; if (bus.ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL stagger_ready k=%0d got %b want %b", k, bus.ready, exp_rdy); end
      vectors++; if (bus.ce !== exp_ce) begin miscompares++; $display("[TB] FAIL align_ce k=%0d got %b want %b", k, bus.ce, exp_ce); end
      vectors++; if (bus0.rst_out !== exp_rst0) begin miscompares++; $display("[TB] FAIL f1_rst_out0 k=%0d got %b want %b", k, bus0.rst_out, exp_rst0); end
      vectors++; if (bus0.ready !== exp_rdy0) begin miscompares++; $display("[TB] FAIL f1_ready0 k=%0d got %b want %b", k, bus0.ready, exp_rdy0); end
      vectors++; if (bus0.ce !== exp_ce0) begin miscompares++; $display("[TB] FAIL div0_ce0 k=%0d got %b want %b", k, bus0.ce, exp_ce0); end
    end
  endtask

`ifdef CLKEN_RUNTIME_DIV_EN
  task automatic test_runtime_div();
    bit   found;
    logic exp_ce, exp_rdy;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (bus.ce[2] === 1'b1) found = 1'b1;
      else tick(1);
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("[TB] FAIL rtdiv_find_pulse got none want ce[2] pulse within 12 cycles");
    end else begin
      tick(1);
      vectors++; if (bus.div_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rtdiv_ready_before got %b want 1", bus.div_wr_ready); end
      bus.div_wr_valid = 1'b1; bus.div_wr_ch = 4'd2; bus.div_wr_val = 8'd6;
      for (int j = 2; j <= 17; j++) begin
        tick(1);
        bus.div_wr_valid = 1'b0;
        exp_ce  = (j == 4) || (j == 10) || (j == 16);
        exp_rdy = (j >= 4);
        vectors++; if (bus.ce[2] !== exp_ce) begin miscompares++; $display("[TB] FAIL rtdiv_ce2 j=%0d got %b want %b", j, bus.ce[2], exp_ce); end
        vectors++; if (bus.div_wr_ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL rtdiv_wr_ready j=%0d got %b want %b", j, bus.div_wr_ready, exp_rdy); end
      end
      bus.div_wr_valid = 1'b1; bus.div_wr_ch = 4'd7; bus.div_wr_val = 8'd0;
      tick(1);
      bus.div_wr_valid = 1'b0;
      vectors++; if (bus.div_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rtdiv_drop_ready got %b want 1", bus.div_wr_ready); end
      bus.div_wr_valid = 1'b1; bus.div_wr_ch = 4'd2; bus.div_wr_val = 8'd4;
      tick(1);
      bus.div_wr_valid = 1'b0;
      vectors++; if (bus.div_wr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rtdiv_pending got %b want 0", bus.div_wr_ready); end
      tick(10);
      vectors++; if (bus.div_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rtdiv_restored got %b want 1", bus.div_wr_ready); end
    end
  endtask
`endif

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    tick(2);
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL loss_still_ready got %b want 1", bus.ready); end
    tick(1);
    vectors++; if (bus.ce !== 3'b000) begin miscompares++; $display("[TB] FAIL loss_ce got %b want 000", bus.ce); end
    vectors++; if (bus.rst_out !== 3'b111) begin miscompares++; $display("[TB] FAIL loss_rst_out got %b want 111", bus.rst_out); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL loss_ready got %b want 0", bus.ready); end
    vectors++; if (bus0.rst_out !== 2'b11) begin miscompares++; $display("[TB] FAIL loss_rst_out0 got %b want 11", bus0.rst_out); end
    test_lock_stagger();
  endtask

  task automatic test_lock_bounce();
    logic [2:0] exp_rst;
    pll_locked = 1'b0;
    tick(4);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      exp_rst = (k < 10) ? 3'b111 : 3'b110;
      vectors++; if (bus.rst_out !== exp_rst) begin miscompares++; $display("[TB] FAIL bounce_rst_out k=%0d got %b want %b", k, bus.rst_out, exp_rst); end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick(1);
    vectors++; if (bus.rst_out !== 3'b111) begin miscompares++; $display("[TB] FAIL midrst_rst_out got %b want 111", bus.rst_out); end
    vectors++; if (bus.ce !== 3'b000) begin miscompares++; $display("[TB] FAIL midrst_ce got %b want 000", bus.ce); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ready got %b want 0", bus.ready); end
    vectors++; if (bus0.ce !== 2'b00) begin miscompares++; $display("[TB] FAIL midrst_ce0 got %b want 00", bus0.ce); end
    vectors++; if (bus0.rst_out !== 2'b11) begin miscompares++; $display("[TB] FAIL midrst_rst_out0 got %b want 11", bus0.rst_out); end
    pll_locked = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);
    vectors++; if (bus.rst_out !== 3'b111) begin miscompares++; $display("[TB] FAIL postrst_rst_out got %b want 111", bus.rst_out); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL postrst_ready got %b want 0", bus.ready); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_lock_stagger();
`ifdef CLKEN_RUNTIME_DIV_EN
    test_runtime_div();
`endif
    test_lock_loss();
    test_lock_bounce();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clken_sequencer.md
# clken_sequencer

Post-PLL clock-enable and reset sequencer. Runs on one PLL output clock and produces NUM_CH phase-aligned clock-enable streams with programmable integer divisors, replacing multiple PLL outputs for low-rate domains. It also produces per-channel synchronous resets, released in a staggered order only after the PLL lock indication has been stable for a programmable time. Sits directly after the PLL wrapper in each board's top level; downstream logic uses `refclk` plus `ce[i]`.

## Interface
- NUM_CH, 3, number of enable/reset channels (1..16)
- DIV_W, 8, divisor width in bits
- DIV_INIT, {8'd4, 8'd1, 8'd1}, packed NUM_CH*DIV_W reset divisors; channel 0 is the LSBs
- LOCK_FILTER, 1024, consecutive synchronised-lock cycles required before release (>=1)
- STAGGER, 16, cycles between successive channel reset releases (>=1)

Ports:
- refclk  in  1  the only clock; a PLL output
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  raw PLL lock, asynchronous to refclk
- ce  out  NUM_CH  per-channel clock-enable pulses
- rst_out  out  NUM_CH  per-channel synchronous active-high resets
- ready  out  1  high while in RUN
- div_wr_valid  in  1  divisor write request (CLKEN_RUNTIME_DIV_EN only)
- div_wr_ch  in  4  target channel
- div_wr_val  in  DIV_W  new divisor
- div_wr_ready  out  1  write accepted when valid && ready

## Operation
- `pll_locked` passes through a 2-FF synchroniser, giving `lk_s`.
- FSM states:
  - WAIT_LOCK:
    - `lock_cnt` counts consecutive `lk_s` high cycles.
    - Any low cycle clears `lock_cnt`.
    - When `lock_cnt == LOCK_FILTER-1` with `lk_s` high, go to RELEASE.
  - RELEASE:
    - `rel_cnt` counts up from 0.
    - `rst_out[i]` deasserts when `rel_cnt == i*STAGGER`.
    - On the cycle `rst_out[NUM_CH-1]` deasserts, go to RUN on the next cycle.
  - RUN:
    - Divider counters run.
    - `ready` = 1.
- `lk_s` low in RELEASE or RUN causes the following on the next cycle:
  - Go to WAIT_LOCK.
  - Set all `rst_out` to 1 and all `ce` to 0.
  - Clear all counters.
- Dividers, one per channel, with a `cnt` of DIV_W bits:
  - Counters are held at 0 outside RUN.
  - In RUN, `cnt` counts 0..div-1 and wraps; `ce[i] = (cnt==0)` while in RUN.
  - div=1 gives `ce` continuously high.
  - div=0 disables the channel: `ce` stays low and `cnt` is held at 0.
- All channels' counters start on the same cycle, so every `ce` pulses on the first RUN cycle. Enables with commensurate divisors are therefore phase-aligned.
- Reset values:
  - State WAIT_LOCK.
  - `ce` = 0, `rst_out` = all 1, `ready` = 0, `div_wr_ready` = 0.
  - Divisors = DIV_INIT.
  - Shadows empty.
- `rst` asserted mid-operation overrides everything on the next edge.

## Timing
- Lock path latency:
  - `pll_locked` rising at edge E gives `lk_s` high at E+2.
  - RELEASE entered at E+2+LOCK_FILTER.
  - `rst_out[0]` falls in the first RELEASE cycle.
- `rst_out[i]` falls STAGGER*i cycles after `rst_out[0]`.
- `ready` and the first `ce` occur one cycle after `rst_out[NUM_CH-1]` falls.
- Lock loss latency: `pll_locked` low gives outputs reset 3 cycles later (2 sync + 1).
- `ce` is registered; its period is exactly div cycles, with no jitter.

## Configuration
- Macro: `CLKEN_RUNTIME_DIV_EN`.
- Defined:
  - `div_wr_ready` = RUN && no shadow pending.
  - An accepted write goes to that channel's shadow register.
  - The shadow loads on that channel's wrap cycle (`cnt == div-1`), or immediately if current div is 0 or 1. The change is glitch-free, with no short or long pulse.
  - `div_wr_ch >= NUM_CH` is accepted and dropped.
  - Shadows are cleared on lock loss; divisors themselves are retained.
- Undefined:
  - The `div_wr_*` ports are absent.
  - Divisors are fixed at DIV_INIT.

## Structure
- Package `clken_pkg`:
  - FSM state enum (WAIT_LOCK, RELEASE, RUN).
  - Function `clog2` used to size `lock_cnt` and `rel_cnt`.
- Sub-module `clken_div`:
  - One per channel, generated NUM_CH times.
  - Holds `cnt`, `div`, the shadow and `ce` generation.
- The top level holds the synchroniser, FSM and reset release.

## Test plan
- **Lock filter and stagger.** Defaults, LOCK_FILTER=8, STAGGER=4; `pll_locked` rises at cycle 10 → `rst_out[0]` falls at cycle 20, `rst_out[1]` at 24, `rst_out[2]` at 28; `ready` high at 29.
- **Lock bounce.** `pll_locked` high for 5 cycles, low 1, then high → the filter restarts; release is delayed 8 cycles after the final rise + 2.
- **Divider alignment.** DIV_INIT {4,1,1} in RUN → `ce[2]` high on cycles 0,4,8,…; `ce[1:0]` continuously high; all three high on the first RUN cycle.
- **Lock loss in RUN.** Drop `pll_locked` → 3 cycles later `ce` = 0, `rst_out` = 3'b111, `ready` = 0; re-lock repeats the full sequence.
- **Runtime divisor (CLKEN_RUNTIME_DIV_EN).** Write ch2 = 6 at `cnt` = 1 → pulses continue at period 4 until the wrap, then period 6; no pulse pair is closer than 4 cycles; `div_wr_ready` is low until the load.
- **Mid-sequence reset.** Assert `rst` during RELEASE → the next cycle shows reset values; a div=0 channel never pulses.
